// File: rtl/clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_switch_ctrl
//
// Purpose:
//   Sequencer for a glitch-free two-source clock switch. It accepts a switch
//   request, drives the registered select to the switch cell, and then tracks
//   the switch's gate enables. First it waits for the old source gate to turn
//   off (BREAK), then it waits for the new source gate to turn on (MAKE).
//   When both have happened it confirms the new source and pulses done.
//   A single cycle budget covers BREAK and MAKE together. If that budget is
//   exhausted, the controller parks in a sticky error state until err_clr.
//
// Parameters:
//   TIMEOUT_CYC  max clk_A cycles for one switch (BREAK+MAKE), 4..1023
//   SYNC_STAGES  depth of the gate_b_en synchronizer, 2..4
//
// Ports:
//   clk_A      in   sole clock, rising edge
//   rstn_A     in   asynchronous active-low reset
//   req_valid  in   switch request valid
//   req_tgt    in   requested source (0 = clk_A, 1 = clk_B)
//   req_ready  out  request is accepted this cycle if req_valid is high
//   sel        out  registered select to the glitch-free switch
//   gate_a_en  in   clk_A-side gate status (already in clk_A domain)
//   gate_b_en  in   clk_B-side gate status (asynchronous)
//   err_clr    in   leaves the error state
//   cur_src    out  confirmed active source
//   done       out  one-cycle pulse when a request completes
//   err        out  high while in the error state
// ---------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_A,
    input  logic rstn_A,
    input  logic req_valid,
    input  logic req_tgt,
    output logic req_ready,
    output logic sel,
    input  logic gate_a_en,
    input  logic gate_b_en,
    input  logic err_clr,
    output logic cur_src,
    output logic done,
    output logic err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAKE  = 3'd2,
        FIN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   cur_src_q, cur_src_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   req_ready_q, req_ready_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic gate_b_s;
    logic old_gate_off;
    logic new_gate_on;
    logic timeout;
    logic [CNT_W-1:0] cnt_inc;

    // ------------------------------------------------------------------
    // gate_b_en synchronizer: a plain shift chain. Bit 0 is the first
    // (metastability-exposed) stage, and the MSB is the usable output.
    // ------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gate_b_en};
    end

    assign gate_b_s = sync_q[SYNC_STAGES-1];

    // BREAK looks at the gate of the source being left (cur_src). MAKE looks
    // at the gate of the source being entered (sel, already loaded at accept).
    assign old_gate_off = cur_src_q ? ~gate_b_s : ~gate_a_en;
    assign new_gate_on  = sel_q     ?  gate_b_s :  gate_a_en;

    assign timeout = (cnt_q == CNT_LAST);
    assign cnt_inc = timeout ? cnt_q : cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so that no path through
        // the case statement leaves a value unassigned. An unassigned path
        // would infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        cur_src_d = cur_src_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_tgt == cur_src_q) begin
                        state_d = FIN;
                    end else begin
                        sel_d   = req_tgt;
                        cnt_d   = '0;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = cnt_inc;
                // A gate transition takes priority over an expiring budget.
                if (old_gate_off) begin
                    state_d = MAKE;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            MAKE: begin
                // The counter keeps running from BREAK. The budget covers
                // the whole switch, not each phase separately.
                cnt_d = cnt_inc;
                if (new_gate_on) begin
                    state_d = FIN;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            FIN: begin
                cur_src_d = sel_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                if (err_clr) begin
                    // Realign the select with the last confirmed source.
                    sel_d   = cur_src_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // These outputs are registered versions of the state being entered,
        // so they line up with state_q on the following cycle.
        req_ready_d = (state_d == IDLE);
        err_d       = (state_d == ERR);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_A or negedge rstn_A) begin
        if (!rstn_A) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            cur_src_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            cnt_q       <= '0;
            sync_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so that
            // every flop samples pre-edge values regardless of statement
            // order.
            state_q     <= state_d;
            sel_q       <= sel_d;
            cur_src_q   <= cur_src_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
        end
    end

    assign req_ready = req_ready_q;
    assign sel       = sel_q;
    assign cur_src   = cur_src_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
